// File: rtl/io_pkg.sv
// Shared IO definitions: minor opcode field values, load-class decode and the
// port-index width rule used by the arbiter and its round-robin pointer.
package io_pkg;

    localparam logic [3:0] LOAD       = 4'b0000;
    localparam logic [3:0] ATOMICLOAD = 4'b0100;
    localparam logic [3:0] STORE      = 4'b1000;
    localparam logic [3:0] STATUSLOAD = 4'b1100;

    // Width of a port index; a single port still needs one bit.
    function automatic int unsigned port_index_width(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    // Plain and status loads return a writeback; bits [3:2] are equal for both.
    function automatic logic is_load_class(input logic [3:0] opcode);
        return opcode[2] == opcode[3];
    endfunction

endpackage

// File: rtl/io_rr_pointer.sv
// Combinational next-pointer logic for the writeback round-robin scheduler.
// The pointer register itself lives in the parent.
module io_rr_pointer
    import io_pkg::*;
#(
    parameter int unsigned PORTCOUNT = 4,
    parameter int unsigned PW        = 2
) (
    input  logic [PORTCOUNT-1:0] pending,
    input  logic                 capture,
    input  logic [PW-1:0]        ptr,
    output logic [PW-1:0]        next_ptr
);

    logic          found;
    logic [PW-1:0] cand;
    int            idx;

    // Scan downward so the nearest pending port after ptr is the last one written.
    always_comb begin
        found = 1'b0;
        cand  = ptr;
        idx   = 0;
        for (int k = int'(PORTCOUNT) - 1; k >= 1; k--) begin
            idx = (int'(ptr) + k) % int'(PORTCOUNT);
            if (pending[idx]) begin
                found = 1'b1;
                cand  = PW'(idx);
            end
        end
    end

    always_comb begin
        next_ptr = ptr;
        if (!capture && pending[ptr]) begin
            next_ptr = ptr;
        end else if (found) begin
            next_ptr = cand;
        end
    end

endmodule

// File: rtl/io_port_arbiter.sv
// Steers core IO commands to PORTCOUNT port controllers and merges their
// writebacks into the single core writeback path via a round-robin grant.
module io_port_arbiter
    import io_pkg::*;
#(
    parameter int unsigned PORTCOUNT    = 4,
    parameter int unsigned DATABITWIDTH = 16
) (
    input  logic                             sys_clk,
    input  logic                             async_rst_n,
    input  logic                             clk_en,

    input  logic                             CommandACK,
    output logic                             CommandREQ,
    input  logic [3:0]                       MinorOpcodeIn,
    input  logic [DATABITWIDTH-1:0]          CommandAddressIn,
    input  logic [DATABITWIDTH-1:0]          CommandDataIn,
    input  logic [3:0]                       CommandDestReg,

    output logic [PORTCOUNT-1:0]             PortCommandACK,
    input  logic [PORTCOUNT-1:0]             PortCommandREQ,
    output logic [3:0]                       PortMinorOpcode,
    output logic [DATABITWIDTH-1:0]          PortAddressOffset,
    output logic [DATABITWIDTH-1:0]          PortData,
    output logic [3:0]                       PortDestReg,

    input  logic [PORTCOUNT-1:0]             PortWritebackACK,
    output logic [PORTCOUNT-1:0]             PortWritebackREQ,
    input  logic [PORTCOUNT*4-1:0]           PortWritebackDestReg,
    input  logic [PORTCOUNT*DATABITWIDTH-1:0] PortWritebackData,

    output logic                             WritebackACK,
    input  logic                             WritebackREQ,
    output logic [3:0]                       WritebackDestReg,
    output logic [DATABITWIDTH-1:0]          WritebackDataOut,

    output logic                             PortError
);

    localparam int unsigned PORTINDEXBITWIDTH = port_index_width(PORTCOUNT);
    localparam int unsigned PW = PORTINDEXBITWIDTH;
    localparam logic [DATABITWIDTH-1:0] OffsetMask =
        {{PW{1'b0}}, {(DATABITWIDTH - PW){1'b1}}};

    // Command stage
    logic                    cmd_valid_q, cmd_valid_d;
    logic [PW-1:0]           cmd_port_q, cmd_port_d;
    logic [3:0]              cmd_opcode_q, cmd_opcode_d;
    logic [DATABITWIDTH-1:0] cmd_offset_q, cmd_offset_d;
    logic [DATABITWIDTH-1:0] cmd_data_q, cmd_data_d;
    logic [3:0]              cmd_dest_q, cmd_dest_d;
    logic                    port_error_q, port_error_d;

    // Writeback stage and scheduler
    logic                    wb_valid_q, wb_valid_d;
    logic [3:0]              wb_dest_q, wb_dest_d;
    logic [DATABITWIDTH-1:0] wb_data_q, wb_data_d;
    logic [PW-1:0]           ptr_q, ptr_d, ptr_next;

    logic                    cmd_drain, cmd_accept, index_valid;
    logic [PW-1:0]           cmd_index;
    logic                    wb_ready, capture;
    logic [PORTCOUNT-1:0]    pending;
    logic [3:0]              sel_dest;
    logic [DATABITWIDTH-1:0] sel_data;

    assign cmd_index   = CommandAddressIn[DATABITWIDTH-1 -: PW];
    assign index_valid = 32'(cmd_index) < PORTCOUNT;
    assign cmd_drain   = cmd_valid_q && PortCommandREQ[cmd_port_q];
    assign CommandREQ  = !cmd_valid_q || cmd_drain;
    assign cmd_accept  = CommandACK && CommandREQ && clk_en;

    always_comb begin
        for (int i = 0; i < int'(PORTCOUNT); i++) begin
            PortCommandACK[i] = cmd_valid_q && (cmd_port_q == PW'(i));
        end
    end

    assign PortMinorOpcode   = cmd_opcode_q;
    assign PortAddressOffset = cmd_offset_q;
    assign PortData          = cmd_data_q;
    assign PortDestReg       = cmd_dest_q;
    assign PortError         = port_error_q;

    always_comb begin
        cmd_valid_d  = cmd_valid_q;
        cmd_port_d   = cmd_port_q;
        cmd_opcode_d = cmd_opcode_q;
        cmd_offset_d = cmd_offset_q;
        cmd_data_d   = cmd_data_q;
        cmd_dest_d   = cmd_dest_q;
        port_error_d = port_error_q;
        if (clk_en && cmd_drain) begin
            cmd_valid_d = 1'b0;
        end
        if (cmd_accept) begin
            if (index_valid) begin
                cmd_valid_d  = 1'b1;
                cmd_port_d   = cmd_index;
                cmd_opcode_d = MinorOpcodeIn;
                cmd_offset_d = CommandAddressIn & OffsetMask;
                cmd_data_d   = CommandDataIn;
                cmd_dest_d   = CommandDestReg;
            end else begin
                port_error_d = 1'b1;
            end
        end
    end

    // Grant depends only on registered state and WritebackREQ, never on port ACKs.
    assign wb_ready = !wb_valid_q || WritebackREQ;

    always_comb begin
        sel_dest = '0;
        sel_data = '0;
        for (int i = 0; i < int'(PORTCOUNT); i++) begin
            PortWritebackREQ[i] = (ptr_q == PW'(i)) && wb_ready;
            if (ptr_q == PW'(i)) begin
                sel_dest = PortWritebackDestReg[i*4 +: 4];
                sel_data = PortWritebackData[i*DATABITWIDTH +: DATABITWIDTH];
            end
        end
    end

    assign capture          = clk_en && wb_ready && PortWritebackACK[ptr_q];
    assign WritebackACK     = wb_valid_q;
    assign WritebackDestReg = wb_dest_q;
    assign WritebackDataOut = wb_data_q;

    always_comb begin
        for (int i = 0; i < int'(PORTCOUNT); i++) begin
            pending[i] = PortWritebackACK[i] ||
                         (cmd_valid_q && (cmd_port_q == PW'(i)) && is_load_class(cmd_opcode_q));
        end
    end

    io_rr_pointer #(
        .PORTCOUNT (PORTCOUNT),
        .PW        (PW)
    ) u_rr_pointer (
        .pending  (pending),
        .capture  (capture),
        .ptr      (ptr_q),
        .next_ptr (ptr_next)
    );

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_dest_d  = wb_dest_q;
        wb_data_d  = wb_data_q;
        ptr_d      = ptr_q;
        if (clk_en) begin
            ptr_d = ptr_next;
            if (capture) begin
                wb_valid_d = 1'b1;
                wb_dest_d  = sel_dest;
                wb_data_d  = sel_data;
            end else if (wb_valid_q && WritebackREQ) begin
                wb_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            cmd_valid_q  <= 1'b0;
            cmd_port_q   <= '0;
            cmd_opcode_q <= '0;
            cmd_offset_q <= '0;
            cmd_data_q   <= '0;
            cmd_dest_q   <= '0;
            port_error_q <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_dest_q    <= '0;
            wb_data_q    <= '0;
            ptr_q        <= '0;
        end else begin
            cmd_valid_q  <= cmd_valid_d;
            cmd_port_q   <= cmd_port_d;
            cmd_opcode_q <= cmd_opcode_d;
            cmd_offset_q <= cmd_offset_d;
            cmd_data_q   <= cmd_data_d;
            cmd_dest_q   <= cmd_dest_d;
            port_error_q <= port_error_d;
            wb_valid_q   <= wb_valid_d;
            wb_dest_q    <= wb_dest_d;
            wb_data_q    <= wb_data_d;
            ptr_q        <= ptr_d;
        end
    end

endmodule
